// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared constants for the pipelined adder slice of the codebase.
//   DEFAULT_WIDTH  : default operand / sum width in bits
//   DEFAULT_STAGES : default pipeline depth
//   chunk_bits()   : width of the operand slice each stage resolves
// The per-stage record type depends on WIDTH, so adder_pipe declares it
// from its own localparams instead of fixing one width here.
// ---------------------------------------------------------------------------
package adder_pkg;

   localparam int DEFAULT_WIDTH  = 32;
   localparam int DEFAULT_STAGES = 4;

   // Number of operand bits resolved by each stage of the pipeline.
   function automatic int chunk_bits(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// ---------------------------------------------------------------------------
// adder_slice
// Purely combinational CHUNK-bit adder used by one pipeline stage.
// Ports:
//   a, b  (in,  CHUNK) operand slices
//   cin   (in,  1)     carry into the slice
//   s     (out, CHUNK) sum slice
//   cout  (out, 1)     carry out of the slice's top bit
// ---------------------------------------------------------------------------
module adder_slice #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   // One extra bit of headroom catches the carry out of the slice.
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/adder_pipe.sv
// ---------------------------------------------------------------------------
// adder_pipe
// Pipelined valid/ready adder computing {cout, s} = a + b + cin. Each of the
// STAGES register stages resolves one CHUNK-bit slice and hands its carry to
// the next stage, so a result appears STAGES edges after acceptance.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid / in_ready operand handshake (a, b, cin)
//   out_valid/out_ready result handshake (s, cout)
//   a, b   (in,  WIDTH) operands
//   cin    (in,  1)     carry-in
//   s      (out, WIDTH) sum mod 2^WIDTH, straight from the last stage
//   cout   (out, 1)     carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module adder_pipe
   import adder_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   localparam int CHUNK = chunk_bits(WIDTH, STAGES);

   // A stage record: the sum bits resolved so far plus the operand bits that
   // later stages still have to add. Remaining operands are shifted down as
   // they are consumed, so every stage adds the low CHUNK bits.
   typedef struct packed {
      logic             valid;
      logic             carry;
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] rem_a;
      logic [WIDTH-1:0] rem_b;
   } stage_t;

   if (WIDTH % STAGES != 0) begin : g_bad_split
      $error("adder_pipe: STAGES must divide WIDTH evenly");
   end

   logic advance;

   // The whole pipe moves in lock-step: it only stops when the consumer
   // refuses a valid result, and then nothing inside moves either.
   assign in_ready = !out_valid || out_ready;
   assign advance  = in_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t           src;
      stage_t           q;
      logic [CHUNK-1:0] slice_s;
      logic             slice_cout;
      logic [WIDTH-1:0] sum_next;

      if (k == 0) begin : g_head
         assign src = '{valid: in_valid && in_ready, carry: cin, sum: '0,
                        rem_a: a, rem_b: b};
      end else begin : g_tail
         assign src = g_stage[k-1].q;
      end

      adder_slice #(
         .CHUNK(CHUNK)
      ) u_slice (
         .a   (src.rem_a[CHUNK-1:0]),
         .b   (src.rem_b[CHUNK-1:0]),
         .cin (src.carry),
         .s   (slice_s),
         .cout(slice_cout)
      );

      // Drop this stage's freshly resolved slice into its place in the sum,
      // keeping the lower slices produced by earlier stages.
      always_comb begin
         sum_next = src.sum;
         sum_next[k*CHUNK +: CHUNK] = slice_s;
      end

      // Stage register: cleared by reset, frozen during a stall, otherwise
      // takes the upstream record with this slice's result folded in.
      always_ff @(posedge clk) begin
         if (rst) begin
            q <= '0;
         end else if (advance) begin
            q.valid <= src.valid;
            q.carry <= slice_cout;
            q.sum   <= sum_next;
            q.rem_a <= src.rem_a >> CHUNK;
            q.rem_b <= src.rem_b >> CHUNK;
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].q.valid;
   assign s         = g_stage[STAGES-1].q.sum;
   assign cout      = g_stage[STAGES-1].q.carry;

endmodule

// File: tb/tb_adder_pipe.sv
// ---------------------------------------------------------------------------
// tb_adder_pipe
// Drives three adder_pipe instances (STAGES = 4, 1, 8) from one stimulus
// stream. Cycle-exact directed sequences are checked on the STAGES=4 copy;
// a per-instance reference queue checks every result of every copy for
// order and value.
// ---------------------------------------------------------------------------
module tb_adder_pipe;

   localparam int NDUT = 3;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] s;
      logic        cout;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        out_ready;

   logic        ir [NDUT];
   logic        ov [NDUT];
   logic        co [NDUT];
   logic [31:0] so [NDUT];

   logic [32:0] sbq [NDUT][$];
   string       dut_name [NDUT] = '{"s4", "s1", "s8"};

   int compared   = 0;
   int mismatched = 0;

   vec_t stream_vecs [8];
   vec_t bp_vecs     [5];
   vec_t rst_vecs    [4];

   always #5 clk = ~clk;

   adder_pipe #(.WIDTH(32), .STAGES(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
      .a(a), .b(b), .cin(cin), .out_valid(ov[0]), .out_ready(out_ready),
      .s(so[0]), .cout(co[0])
   );

   adder_pipe #(.WIDTH(32), .STAGES(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
      .a(a), .b(b), .cin(cin), .out_valid(ov[1]), .out_ready(out_ready),
      .s(so[1]), .cout(co[1])
   );

   adder_pipe #(.WIDTH(32), .STAGES(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
      .a(a), .b(b), .cin(cin), .out_valid(ov[2]), .out_ready(out_ready),
      .s(so[2]), .cout(co[2])
   );

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference queues: a transfer pushes the plain 33-bit sum, a consumed
   // result must match the oldest entry. Reset empties every queue.
   task automatic scoreboardStep();
      logic [32:0] expv;
      for (int d = 0; d < NDUT; d++) begin
         if (rst) begin
            sbq[d].delete();
         end else begin
            if (ov[d] && out_ready) begin
               compared++;
               if (sbq[d].size() == 0) begin
                  mismatched++;
                  $display("[TB] FAIL sb_%s: got result %h_%h with no operation outstanding",
                           dut_name[d], co[d], so[d]);
               end else begin
                  expv = sbq[d].pop_front();
                  if ({co[d], so[d]} !== expv) begin
                     mismatched++;
                     $display("[TB] FAIL sb_%s: got %h_%h required %h_%h",
                              dut_name[d], co[d], so[d], expv[32], expv[31:0]);
                  end
               end
            end
            if (in_valid && ir[d])
               sbq[d].push_back({1'b0, a} + {1'b0, b} + {32'd0, cin});
         end
      end
   endtask

   // Drive one cycle's inputs, let them settle, then run the queues.
   task automatic applyStimulus(input logic r, input logic v,
                                input logic [31:0] aa, input logic [31:0] bb,
                                input logic c, input logic ordy);
      rst       = r;
      in_valid  = v;
      a         = aa;
      b         = bb;
      cin       = c;
      out_ready = ordy;
      #3;
      scoreboardStep();
   endtask

   task automatic checkOutput(input string name, input logic ev,
                              input logic [31:0] es, input logic ec,
                              input logic chk_data);
      compared++;
      if (ov[0] !== ev) begin
         mismatched++;
         $display("[TB] FAIL %s: out_valid=%b required %b", name, ov[0], ev);
      end
      if (chk_data) begin
         compared++;
         if ({co[0], so[0]} !== {ec, es}) begin
            mismatched++;
            $display("[TB] FAIL %s: cout/s=%b/%h required %b/%h",
                     name, co[0], so[0], ec, es);
         end
      end
   endtask

   task automatic checkReady(input string name, input logic er);
      compared++;
      if (ir[0] !== er) begin
         mismatched++;
         $display("[TB] FAIL %s: in_ready=%b required %b", name, ir[0], er);
      end
   endtask

   initial begin
      int accepted;
      int cyc;
      logic        rv, ro, rc;
      logic [31:0] ra, rb;

      stream_vecs[0] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
      stream_vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
      stream_vecs[2] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'hFFFFFFFF, 1'b0};
      stream_vecs[3] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0};
      stream_vecs[4] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
      stream_vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
      stream_vecs[6] = '{32'h0000FFFF, 32'h0000FFFF, 1'b1, 32'h0001FFFF, 1'b0};
      stream_vecs[7] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};

      bp_vecs[0] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};
      bp_vecs[1] = '{32'h11111111, 32'h22222222, 1'b1, 32'h33333334, 1'b0};
      bp_vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0};
      bp_vecs[3] = '{32'hFFFF0000, 32'h00010000, 1'b0, 32'h00000000, 1'b1};
      bp_vecs[4] = '{32'h00000001, 32'h00000001, 1'b1, 32'h00000003, 1'b0};

      rst_vecs[0] = '{32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0};
      rst_vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
      rst_vecs[2] = '{32'h40000000, 32'h40000000, 1'b0, 32'h80000000, 1'b0};
      rst_vecs[3] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 1'b1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      out_ready = 1'b1;

      // Reset held over two edges, then released.
      tick();
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput("reset", 1'b0, 32'h0, 1'b0, 1'b1);
      checkReady("reset_ready", 1'b1);

      // Carry ripples through every chunk boundary.
      tick();
      applyStimulus(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1);
      checkReady("ripple_accept", 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
         if (i < 3) checkOutput("ripple_wait", 1'b0, 32'h0, 1'b0, 1'b0);
         else       checkOutput("ripple", 1'b1, 32'h00000000, 1'b1, 1'b1);
      end

      // Back-to-back stream: one op per cycle, results 4 cycles later.
      for (int t = 0; t < 12; t++) begin
         tick();
         if (t < 8)
            applyStimulus(1'b0, 1'b1, stream_vecs[t].a, stream_vecs[t].b,
                          stream_vecs[t].cin, 1'b1);
         else
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
         if (t >= 4)
            checkOutput($sformatf("stream%0d", t - 4), 1'b1, stream_vecs[t-4].s,
                        stream_vecs[t-4].cout, 1'b1);
         else
            checkOutput("stream_empty", 1'b0, 32'h0, 1'b0, 1'b0);
      end

      // Backpressure: fill the pipe, stall for 5 cycles with junk offered.
      for (int t = 0; t < 15; t++) begin
         tick();
         if (t < 4)
            applyStimulus(1'b0, 1'b1, bp_vecs[t].a, bp_vecs[t].b, bp_vecs[t].cin, 1'b1);
         else if (t < 9)
            applyStimulus(1'b0, 1'b1, 32'hDEADBEEF ^ 32'(t), 32'h0BADF00D, 1'b1, 1'b0);
         else if (t == 9)
            applyStimulus(1'b0, 1'b1, bp_vecs[4].a, bp_vecs[4].b, bp_vecs[4].cin, 1'b1);
         else
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
         if (t < 4) begin
            checkOutput("bp_fill", 1'b0, 32'h0, 1'b0, 1'b0);
         end else if (t < 9) begin
            checkReady("bp_stall_ready", 1'b0);
            checkOutput("bp_hold", 1'b1, bp_vecs[0].s, bp_vecs[0].cout, 1'b1);
         end else if (t < 14) begin
            if (t == 9) checkReady("bp_resume_ready", 1'b1);
            checkOutput($sformatf("bp_drain%0d", t - 9), 1'b1, bp_vecs[t-9].s,
                        bp_vecs[t-9].cout, 1'b1);
         end else begin
            checkOutput("bp_empty", 1'b0, 32'h0, 1'b0, 1'b0);
         end
      end

      // Reset with three ops in flight; a transfer offered alongside rst
      // must also be dropped.
      for (int t = 0; t < 9; t++) begin
         tick();
         if (t < 3)
            applyStimulus(1'b0, 1'b1, rst_vecs[t].a, rst_vecs[t].b, rst_vecs[t].cin, 1'b1);
         else if (t == 3)
            applyStimulus(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
         else if (t == 4)
            applyStimulus(1'b0, 1'b1, rst_vecs[3].a, rst_vecs[3].b, rst_vecs[3].cin, 1'b1);
         else
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
         if (t == 4) checkReady("rst_ready", 1'b1);
         if (t >= 4 && t < 8)
            checkOutput("rst_flushed", 1'b0, 32'h0, 1'b0, 1'b0);
         else if (t == 8)
            checkOutput("rst_next_op", 1'b1, rst_vecs[3].s, rst_vecs[3].cout, 1'b1);
      end

      // Random traffic with random valid and ready.
      accepted = 0;
      cyc      = 0;
      while (accepted < 1000 && cyc < 20000) begin
         tick();
         rv = ($urandom_range(0, 3) != 0);
         ro = ($urandom_range(0, 3) != 0);
         rc = 1'($urandom_range(0, 1));
         ra = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
         applyStimulus(1'b0, rv, ra, rb, rc, ro);
         if (rv && ir[0]) accepted++;
         cyc++;
      end
      compared++;
      if (accepted < 1000) begin
         mismatched++;
         $display("[TB] FAIL random_budget: accepted %0d ops required 1000", accepted);
      end

      // Drain every pipe and confirm nothing is left outstanding.
      for (int i = 0; i < 30; i++) begin
         tick();
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      end
      for (int d = 0; d < NDUT; d++) begin
         compared++;
         if (sbq[d].size() != 0 || ov[d] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL drain_%s: %0d results outstanding, out_valid=%b required 0 and 0",
                     dut_name[d], sbq[d].size(), ov[d]);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
